alu_exec_stage: RTL
===================

# alu_exec_stage

Registered execute stage that sits directly downstream of the ARM-opcode-to-ALU-control adapter. It consumes the 4-bit ALU control code together with two operands and computes the result. It holds the architected NZCV flag register, updating it on request. Results are buffered in a 2-entry output queue with valid/ready handshakes on both sides, so the writeback stage can stall without losing operations.

## Interface
- WIDTH, 32, operand/result width (≥ 2)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  stage can accept this cycle
- alu_ctrl  in  4  ALU control code from the opcode adapter
- src_a  in  WIDTH  operand A (Rn)
- src_b  in  WIDTH  operand B (shifted operand / immediate)
- set_flags  in  1  update NZCV with this operation's flags (S bit)
- wb_en  in  1  result is written back (0 for compare-type ops); passed through
- out_valid  out  1  head entry of output queue is valid
- out_ready  in  1  downstream consumes head entry
- result  out  WIDTH  head entry result
- out_wb_en  out  1  head entry wb_en
- out_illegal  out  1  head entry had an unsupported alu_ctrl
- flags  out  4  architected {N,Z,C,V} register

## Operation
- Control codes: 0000 ADD (A+B); 0001 SUB (A−B); 0111 AND; 1001 XOR; 1010 MOV (result=B). Any other code gives result 0 and illegal=1, and never updates flags, even if set_flags=1.
- Arithmetic is done at WIDTH+1 bits; result is the low WIDTH bits, wrap-around with no saturation.
- N = result[WIDTH−1]; Z = (result == 0).
- ADD: C = carry out of bit WIDTH−1; V = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
- SUB: C = NOT borrow, so C=1 iff A ≥ B unsigned; V = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- AND/XOR/MOV: C and V keep their current register value; only N and Z are new.
- Accept = in_valid && in_ready. On accept, the computed {result, wb_en, illegal} is pushed into the queue tail. If set_flags is 1 and the code is legal, flags are loaded with the new NZCV on the same edge.
- Flags are updated at accept, not at dequeue. A back-to-back accepted op therefore sees nothing stale; flag consumers read `flags` after the accept edge.
- Pop = out_valid && out_ready; removes the head entry.
- Queue: 2 entries and a count of 0..2. in_ready = (count < 2), driven combinationally from count only and never from out_ready. out_valid = (count > 0).
- Count transitions:
  - accept only: +1
  - pop only: −1
  - accept and pop together (count = 1): count stays 1, old head leaves, new entry becomes head
  - at count 2 no accept is possible
- Output fields are stable while out_valid=1 and out_ready=0.
- in_valid is not required to stay high, and inputs are not latched when in_ready=0.

## Timing
- Latency: accept at edge k → entry visible at outputs after edge k (out_valid=1 in cycle k+1) when the queue was empty.
- Throughput: 1 op/cycle while out_ready=1.
- Reset (rst_n=0 at an edge):
  - count=0, out_valid=0, in_ready=1 in the following cycle
  - result=0, out_wb_en=0, out_illegal=0, flags=4'b0000
- Reset mid-operation discards all queued entries and any same-edge accept. Reset has priority over accept and pop.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=1, flags=0000, and nothing is enqueued.
- ADD flags (WIDTH=32): A=0x7FFFFFFF, B=1, ctrl=0000, S=1 → result=0x80000000 next cycle, flags=1001. Then A=0xFFFFFFFF, B=1, S=1 → result=0, flags=0110.
- SUB/compare: A=5, B=5, ctrl=0001, S=1, wb_en=0 → result=0, out_wb_en=0, flags=0110. Then A=3, B=5 → result=0xFFFFFFFE, flags=1000.
- Logical keeps C/V: set flags to 0011 via an ADD, then AND A=0xF0, B=0x0F, S=1 → result=0, flags=0111. Then XOR with S=0 → flags unchanged.
- Backpressure: out_ready=0 while issuing 3 ops → in_ready drops after 2 accepts and the third is held. Raise out_ready → entries appear in order, with one simultaneous accept+pop at count 1 that keeps count at 1.
- Illegal and reset mid-flight: ctrl=0011, S=1 → out_illegal=1, result=0, flags unchanged. Fill the queue, then pulse rst_n=0 → out_valid=0 the next cycle and flags=0000.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - operation/result handshake bundle for the ALU execute stage
interface alu_exec_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             set_flags;
   logic             wb_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             out_wb_en;
   logic             out_illegal;
   logic [3:0]       flags;

   // Issuing side: offers operations upstream and consumes results downstream.
   modport master (
      output in_valid, alu_ctrl, src_a, src_b, set_flags, wb_en, out_ready,
      input  in_ready, out_valid, result, out_wb_en, out_illegal, flags
   );

   // Execute stage side.
   modport slave (
      input  in_valid, alu_ctrl, src_a, src_b, set_flags, wb_en, out_ready,
      output in_ready, out_valid, result, out_wb_en, out_illegal, flags
   );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered ALU execute stage with NZCV flags and 2-entry result queue
module alu_exec_stage #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_exec_stage_if.slave   bus
);
   localparam logic [3:0] CTRL_ADD = 4'b0000;
   localparam logic [3:0] CTRL_SUB = 4'b0001;
   localparam logic [3:0] CTRL_AND = 4'b0111;
   localparam logic [3:0] CTRL_XOR = 4'b1001;
   localparam logic [3:0] CTRL_MOV = 4'b1010;

   // Queue entry layout: {result, wb_en, illegal}
   localparam int EW = WIDTH + 2;

   logic [EW-1:0] slot0_q, slot0_d;   // head
   logic [EW-1:0] slot1_q, slot1_d;   // second entry, valid only at count 2
   logic [1:0]    count_q, count_d;
   logic [3:0]    flags_q, flags_d;

   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [WIDTH-1:0] res_c;
   logic             illegal_c;
   logic             n_c, z_c, c_c, v_c;
   logic             accept;
   logic             pop;
   logic [EW-1:0]    new_entry;

   // in_ready depends on count only, so out_ready never reaches it combinationally.
   assign bus.in_ready    = (count_q < 2'd2);
   assign bus.out_valid   = (count_q != 2'd0);
   assign bus.result      = slot0_q[EW-1:2];
   assign bus.out_wb_en   = slot0_q[1];
   assign bus.out_illegal = slot0_q[0];
   assign bus.flags       = flags_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign pop       = bus.out_valid && bus.out_ready;
   assign new_entry = {res_c, bus.wb_en, illegal_c};

   // Compute the result and candidate NZCV; logical ops and MOV carry C/V forward.
   always_comb begin
      sum_w     = {1'b0, bus.src_a} + {1'b0, bus.src_b};
      diff_w    = {1'b0, bus.src_a} - {1'b0, bus.src_b};
      res_c     = '0;
      illegal_c = 1'b0;
      c_c       = flags_q[1];
      v_c       = flags_q[0];
      case (bus.alu_ctrl)
         CTRL_ADD: begin
            res_c = sum_w[WIDTH-1:0];
            c_c   = sum_w[WIDTH];
            v_c   = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != bus.src_a[WIDTH-1]);
         end
         CTRL_SUB: begin
            res_c = diff_w[WIDTH-1:0];
            // Bit WIDTH of the widened difference is the borrow; C is its inverse.
            c_c   = ~diff_w[WIDTH];
            v_c   = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != bus.src_a[WIDTH-1]);
         end
         CTRL_AND: res_c = bus.src_a & bus.src_b;
         CTRL_XOR: res_c = bus.src_a ^ bus.src_b;
         CTRL_MOV: res_c = bus.src_b;
         default:  illegal_c = 1'b1;
      endcase
      n_c = res_c[WIDTH-1];
      z_c = (res_c == '0);
   end

   // Queue and flag next-state; simultaneous accept+pop only occurs at count 1.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      flags_d = flags_q;
      case ({accept, pop})
         2'b10: begin
            if (count_q == 2'd0) slot0_d = new_entry;
            else                 slot1_d = new_entry;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: slot0_d = new_entry;
         default: ;
      endcase
      if (accept && bus.set_flags && !illegal_c) begin
         flags_d = {n_c, z_c, c_c, v_c};
      end
   end

   // State registers; reset discards queued entries and any same-edge accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
         flags_q <= 4'b0000;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
         flags_q <= flags_d;
      end
   end
endmodule
